// File: rtl/cdr_loop_if.sv
// Port bundle between the clock_recovery top / phase detector and cdr_loop_ctrl.
// The hold signal exists only when CDR_HOLDOVER_EN is defined.
interface cdr_loop_if #(
    parameter int unsigned ACC_W = 16
);
    logic             enable;
    logic             up;
    logic             down;
`ifdef CDR_HOLDOVER_EN
    logic             hold;
`endif
    logic             vco_clk;
    logic [ACC_W-1:0] inc;
    logic             locked;
    logic [1:0]       state;

`ifdef CDR_HOLDOVER_EN
    modport master (output enable, up, down, hold, input vco_clk, inc, locked, state);
    modport slave  (input enable, up, down, hold, output vco_clk, inc, locked, state);
`else
    modport master (output enable, up, down, input vco_clk, inc, locked, state);
    modport slave  (input enable, up, down, output vco_clk, inc, locked, state);
`endif
endinterface

// File: rtl/cdr_loop_ctrl.sv
// CDR loop controller: PD integrator, NCO and acquire/track/lock sequencer.
// Optional holdover (hold input) is built when CDR_HOLDOVER_EN is defined.
module cdr_loop_ctrl #(
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned NOM_INC    = 4096,
    parameter int unsigned ADJ_W      = 8,
    parameter int unsigned ACQ_CNT    = 8,
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input logic       clk,
    input logic       rst,
    cdr_loop_if.slave bus
);

    localparam int unsigned QCNT_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned NCNT_W = $clog2(UNLOCK_CNT + 1);
    localparam int unsigned SUM_W  = ADJ_W + 3;
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((2 ** (ADJ_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ADJ_W-1:0]  corr_q, corr_d;
    logic [QCNT_W-1:0]        qcnt_q, qcnt_d, qcnt_inc_c;
    logic [NCNT_W-1:0]        ncnt_q, ncnt_d, ncnt_inc_c;
    logic [ACC_W-1:0]         phase_q, inc_q;
    logic                     vco_q, locked_q;

    logic                     frozen_c, quiet_c, sat_hit_c;
    logic                     acq_gain_c, locked_c;
    logic signed [1:0]        err_c;
    logic signed [SUM_W-1:0]  step_c, sum_c, corr_sat_c;
    logic signed [ADJ_W-1:0]  corr_new_c;

    // Phase error; holdover blanks it while the loop is running.
    always_comb begin
        frozen_c = 1'b0;
`ifdef CDR_HOLDOVER_EN
        frozen_c = bus.hold && (state_q != IDLE);
`endif
        err_c = 2'sb00;
        if (!frozen_c) begin
            if (bus.up && !bus.down)      err_c = 2'sb01;
            else if (bus.down && !bus.up) err_c = 2'sb11;
        end
        quiet_c = (err_c == 2'sb00);
    end

    // Saturating integrator and run-length counters, before any state-change clearing.
    always_comb begin
        step_c = {{(SUM_W-2){err_c[1]}}, err_c};
        if (acq_gain_c) step_c = step_c <<< 2;
        sum_c = $signed({{3{corr_q[ADJ_W-1]}}, corr_q}) + step_c;
        if (sum_c > SAT_HI)      corr_sat_c = SAT_HI;
        else if (sum_c < SAT_LO) corr_sat_c = SAT_LO;
        else                     corr_sat_c = sum_c;
        corr_new_c = corr_sat_c[ADJ_W-1:0];
        // Only a push into the rail counts as hitting it; resting there does not.
        sat_hit_c = !quiet_c && ((corr_sat_c == SAT_HI) || (corr_sat_c == SAT_LO));

        if (!quiet_c)                          qcnt_inc_c = '0;
        else if (qcnt_q == QCNT_W'(LOCK_CNT))  qcnt_inc_c = qcnt_q;
        else                                   qcnt_inc_c = qcnt_q + QCNT_W'(1);

        if (quiet_c)                             ncnt_inc_c = '0;
        else if (ncnt_q == NCNT_W'(UNLOCK_CNT))  ncnt_inc_c = ncnt_q;
        else                                     ncnt_inc_c = ncnt_q + NCNT_W'(1);
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state; enable drop wins, saturation beats lock/unlock counts.
    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else if (!frozen_c) begin
            case (state_q)
                IDLE:    state_d = ACQUIRE;
                ACQUIRE: if (qcnt_inc_c == QCNT_W'(ACQ_CNT)) state_d = TRACK;
                TRACK: begin
                    if (sat_hit_c)                               state_d = ACQUIRE;
                    else if (qcnt_inc_c == QCNT_W'(LOCK_CNT))    state_d = LOCKED;
                end
                LOCKED: begin
                    if (sat_hit_c)                               state_d = ACQUIRE;
                    else if (ncnt_inc_c == NCNT_W'(UNLOCK_CNT))  state_d = TRACK;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: state-decoded controls.
    always_comb begin
        acq_gain_c = 1'b0;
        locked_c   = 1'b0;
        case (state_q)
            ACQUIRE: acq_gain_c = 1'b1;
            LOCKED:  locked_c   = 1'b1;
            default: ;
        endcase
    end

    // Loop register updates; counters restart on every state change.
    always_comb begin
        corr_d = corr_q;
        qcnt_d = qcnt_q;
        ncnt_d = ncnt_q;
        if (!bus.enable || (state_q == IDLE)) begin
            corr_d = '0;
            qcnt_d = '0;
            ncnt_d = '0;
        end else if (!frozen_c) begin
            corr_d = corr_new_c;
            if (state_d != state_q) begin
                qcnt_d = '0;
                ncnt_d = '0;
            end else begin
                qcnt_d = qcnt_inc_c;
                ncnt_d = ncnt_inc_c;
            end
        end
    end

    // Integrator, increment and NCO pipeline.
    always_ff @(posedge clk) begin
        if (rst || !bus.enable) begin
            corr_q   <= '0;
            qcnt_q   <= '0;
            ncnt_q   <= '0;
            inc_q    <= ACC_W'(NOM_INC);
            phase_q  <= '0;
            vco_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            corr_q   <= corr_d;
            qcnt_q   <= qcnt_d;
            ncnt_q   <= ncnt_d;
            inc_q    <= ACC_W'(NOM_INC) + ACC_W'(corr_q);
            phase_q  <= (state_q == IDLE) ? '0 : phase_q + inc_q;
            vco_q    <= phase_q[ACC_W-1];
            locked_q <= locked_c;
        end
    end

    assign bus.state   = state_q;
    assign bus.inc     = inc_q;
    assign bus.vco_clk = vco_q;
    assign bus.locked  = locked_q;

endmodule

// File: tb/tb_cdr_loop_ctrl.sv
// Directed bench for cdr_loop_ctrl; the holdover step is compiled in with CDR_HOLDOVER_EN.
module tb_cdr_loop_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cdr_loop_if #(.ACC_W(16)) bus ();

    cdr_loop_ctrl #(
        .ACC_W(16), .NOM_INC(4096), .ADJ_W(8),
        .ACQ_CNT(8), .LOCK_CNT(32), .UNLOCK_CNT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rising-edge spacing and high time of vco_clk over a bounded window.
    task automatic measure_vco(output int per, output int high);
        int   t0, t1;
        logic prev;
        t0 = -1; t1 = -1; high = 0;
        prev = bus.vco_clk;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (!prev && bus.vco_clk) begin
                if (t0 < 0)      t0 = i;
                else if (t1 < 0) t1 = i;
            end
            if (t0 >= 0 && t1 < 0 && bus.vco_clk) high++;
            prev = bus.vco_clk;
        end
        per = (t1 >= 0) ? (t1 - t0) : -1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"},  32'(bus.state),   32'd0);
        chk({tag, "_inc"},    32'(bus.inc),     32'd4096);
        chk({tag, "_vco"},    32'(bus.vco_clk), 32'd0);
        chk({tag, "_locked"}, 32'(bus.locked),  32'd0);
    endtask

    initial begin
        int per, high, toggles;
        logic prev;

        rst = 1'b1;
        bus.enable = 1'b0;
        bus.up     = 1'b0;
        bus.down   = 1'b0;
`ifdef CDR_HOLDOVER_EN
        bus.hold   = 1'b0;
`endif
        tick(2);
        chk_idle("reset");

        // Quiet run: ACQUIRE, TRACK after 8, LOCKED after 32 more.
        rst = 1'b0;
        bus.enable = 1'b1;
        tick(1);  chk("acq_entry", 32'(bus.state), 32'd1);
        tick(7);  chk("acq_hold7", 32'(bus.state), 32'd1);
        tick(1);  chk("track_entry", 32'(bus.state), 32'd2);
        chk("track_unlocked", 32'(bus.locked), 32'd0);
        tick(31); chk("track_hold31", 32'(bus.state), 32'd2);
        tick(1);  chk("lock_entry", 32'(bus.state), 32'd3);
        chk("lock_flag_lag", 32'(bus.locked), 32'd0);
        tick(1);  chk("lock_flag", 32'(bus.locked), 32'd1);
        chk("nominal_inc", 32'(bus.inc), 32'd4096);
        measure_vco(per, high);
        chk("vco_period", 32'(per), 32'd16);
        chk("vco_high", 32'(high), 32'd8);

        // LOCKED robustness and unlock.
        bus.up = 1'b1; bus.down = 1'b1;
        tick(10); chk("both_high_lock", 32'(bus.state), 32'd3);
        bus.up = 1'b0;
        tick(3);
        bus.down = 1'b0;
        tick(1);  chk("noisy3_lock", 32'(bus.state), 32'd3);
        chk("noisy3_locked", 32'(bus.locked), 32'd1);
        bus.down = 1'b1;
        tick(3);  chk("noisy4_pre", 32'(bus.state), 32'd3);
        tick(1);  chk("unlock_state", 32'(bus.state), 32'd2);
        bus.down = 1'b0;
        tick(1);  chk("unlock_flag", 32'(bus.locked), 32'd0);
        chk("unlock_inc", 32'(bus.inc), 32'd4089);

        // Relock, then a one-cycle enable drop.
        tick(31); chk("relock", 32'(bus.state), 32'd3);
        bus.enable = 1'b0;
        tick(1);  chk_idle("en_drop");

        // ACQUIRE gain of 4, then TRACK gain of 1.
        bus.enable = 1'b1;
        tick(1);  chk("reacq", 32'(bus.state), 32'd1);
        bus.up = 1'b1;
        tick(3);
        bus.up = 1'b0;
        tick(1);  chk("acq_gain_inc", 32'(bus.inc), 32'd4108);
        tick(7);  chk("track_after_gain", 32'(bus.state), 32'd2);
        bus.down = 1'b1;
        tick(1);
        bus.down = 1'b0;
        tick(1);  chk("track_gain_inc", 32'(bus.inc), 32'd4107);

        // Clamp at both rails without wrap.
        bus.enable = 1'b0;
        tick(1);
        bus.enable = 1'b1;
        tick(1);
        bus.up = 1'b1;
        tick(40);
        bus.up = 1'b0;
        tick(1);  chk("clamp_hi_inc", 32'(bus.inc), 32'd4223);
        bus.down = 1'b1;
        tick(300);
        bus.down = 1'b0;
        tick(1);  chk("clamp_lo_inc", 32'(bus.inc), 32'd3969);
        chk("clamp_state", 32'(bus.state), 32'd1);

        // Synchronous reset mid-ACQUIRE.
        rst = 1'b1;
        tick(1);  chk_idle("rst_mid");
        rst = 1'b0;

        // Saturation in TRACK falls back to ACQUIRE.
        tick(1);
        bus.up = 1'b1;
        tick(31);
        bus.up = 1'b0;
        tick(8);  chk("sat_track_state", 32'(bus.state), 32'd2);
        chk("sat_track_inc", 32'(bus.inc), 32'd4220);
        bus.up = 1'b1;
        tick(2);  chk("near_rail_state", 32'(bus.state), 32'd2);
        tick(1);  chk("rail_hit_state", 32'(bus.state), 32'd1);
        bus.up = 1'b0;

`ifdef CDR_HOLDOVER_EN
        // Holdover freezes the loop while the NCO free-runs at the held increment.
        bus.enable = 1'b0;
        tick(1);
        bus.enable = 1'b1;
        tick(1);
        bus.up = 1'b1;
        tick(1);
        bus.up = 1'b0;
        tick(8);  chk("hold_pre_state", 32'(bus.state), 32'd2);
        chk("hold_pre_inc", 32'(bus.inc), 32'd4100);
        bus.hold = 1'b1;
        bus.up   = 1'b1;
        toggles  = 0;
        prev     = bus.vco_clk;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.vco_clk !== prev) toggles++;
            prev = bus.vco_clk;
        end
        chk("hold_inc", 32'(bus.inc), 32'd4100);
        chk("hold_state", 32'(bus.state), 32'd2);
        chk("hold_vco_runs", 32'(toggles >= 2), 32'd1);
        bus.hold = 1'b0;
        bus.up   = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
